// File: rtl/uart_rx_word_assembler_pkg.sv
// Shared definitions for the UART receive word assembler: state encoding,
// default byte width and a width helper used for counter sizing.
package uart_rx_word_assembler_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    localparam int BYTE_W_DEFAULT = 8;

    // Bits needed to count up to value-1, never less than one bit.
    function automatic int clog2_min1(input int value);
        return ($clog2(value) < 1) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/uart_rx_word_assembler_if.sv
// Byte-in / word-out bundle between uart_rx, the word assembler and the
// debug controller. The master side supplies bytes; the slave assembles words.
interface uart_rx_word_assembler_if
    import uart_rx_word_assembler_pkg::*;
#(
    parameter int NBITS  = 32,
    parameter int BYTE_W = BYTE_W_DEFAULT
);
    localparam int CNT_W = clog2_min1(NBITS / BYTE_W);

    logic [BYTE_W-1:0] rx_byte;
    logic              rx_byte_done;
    logic              flush;
    logic [NBITS-1:0]  word_data;
    logic              word_done;
    logic              timeout_err;
    logic [CNT_W-1:0]  byte_cnt;

    modport master (
        output rx_byte, rx_byte_done, flush,
        input  word_data, word_done, timeout_err, byte_cnt
    );

    modport slave (
        input  rx_byte, rx_byte_done, flush,
        output word_data, word_done, timeout_err, byte_cnt
    );
endinterface

// File: rtl/uart_rx_word_assembler_inter_byte_timer.sv
// Idle-cycle counter between bytes of one word. expire pulses on the idle
// cycle that would bring the idle count to TIMEOUT_CYC; clr always wins.
// TIMEOUT_CYC = 0 removes the counter entirely.
module inter_byte_timer
    import uart_rx_word_assembler_pkg::*;
#(
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    generate
        if (TIMEOUT_CYC == 0) begin : g_off
            logic unused_inputs;
            assign unused_inputs = &{1'b0, clk, rst, clr, en};
            assign expire        = 1'b0;
        end else begin : g_on
            localparam int              TO_W = clog2_min1(TIMEOUT_CYC + 1);
            localparam logic [TO_W-1:0] LAST = TO_W'(TIMEOUT_CYC - 1);

            logic [TO_W-1:0] count;

            assign expire = en && !clr && (count == LAST);

            // Idle counter: cleared by a byte, flush or expiry; runs only when enabled.
            always_ff @(posedge clk or negedge rst) begin
                // NOTE: sequential state uses non-blocking assignments so every
                // flop samples pre-edge values regardless of process order.
                if (!rst) begin
                    count <= '0;
                end else if (clr || expire) begin
                    count <= '0;
                end else if (en) begin
                    count <= count + 1'b1;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/uart_rx_word_assembler.sv
// Collects NBITS/BYTE_W consecutive UART bytes into one word and strobes
// word_done for one cycle when it completes. A stalled partial word is dropped
// after TIMEOUT_CYC idle cycles (timeout_err strobe) or on flush (silent).
module uart_rx_word_assembler
    import uart_rx_word_assembler_pkg::*;
#(
    parameter int NBITS       = 32,
    parameter int BYTE_W      = BYTE_W_DEFAULT,
    parameter int LSB_FIRST   = 1,
    parameter int TIMEOUT_CYC = 100000
) (
    input logic                     clk,
    input logic                     rst,
    uart_rx_word_assembler_if.slave bus
);

    localparam int               NBYTES    = NBITS / BYTE_W;
    localparam int               CNT_W     = clog2_min1(NBYTES);
    localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(NBYTES - 1);

    state_t           state, state_n;
    logic [CNT_W-1:0] byte_cnt, cnt_n;
    logic [NBITS-1:0] asm_reg, asm_n;
    logic [NBITS-1:0] word_data, word_n;
    logic             word_done, done_n;
    logic             timeout_err, terr_n;
    logic [CNT_W-1:0] slot;
    logic [NBITS-1:0] merged;
    logic             expire;

    inter_byte_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clr    (bus.rx_byte_done || bus.flush),
        .en     (state == COLLECT),
        .expire (expire)
    );

    // Slot for the incoming byte: first byte lowest, or first byte highest.
    assign slot = (LSB_FIRST != 0) ? byte_cnt : (LAST_SLOT - byte_cnt);

    // Next-state logic: flush beats a byte, a byte beats a timeout.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // through the if/else chain can leave it unassigned and infer a latch.
        state_n = state;
        cnt_n   = byte_cnt;
        asm_n   = asm_reg;
        word_n  = word_data;
        done_n  = 1'b0;
        terr_n  = 1'b0;
        merged  = asm_reg;
        merged[slot * BYTE_W +: BYTE_W] = bus.rx_byte;

        if (bus.flush) begin
            state_n = IDLE;
            cnt_n   = '0;
            asm_n   = '0;
        end else if (bus.rx_byte_done) begin
            if (byte_cnt == LAST_SLOT) begin
                word_n  = merged;
                done_n  = 1'b1;
                state_n = IDLE;
                cnt_n   = '0;
                asm_n   = '0;
            end else begin
                asm_n   = merged;
                cnt_n   = byte_cnt + 1'b1;
                state_n = COLLECT;
            end
        end else if (expire) begin
            terr_n  = 1'b1;
            state_n = IDLE;
            cnt_n   = '0;
            asm_n   = '0;
        end
    end

    // State, assembly and registered output strobes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            byte_cnt    <= '0;
            asm_reg     <= '0;
            word_data   <= '0;
            word_done   <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_n;
            byte_cnt    <= cnt_n;
            asm_reg     <= asm_n;
            word_data   <= word_n;
            word_done   <= done_n;
            timeout_err <= terr_n;
        end
    end

    assign bus.word_data   = word_data;
    assign bus.word_done   = word_done;
    assign bus.timeout_err = timeout_err;
    assign bus.byte_cnt    = byte_cnt;

endmodule

// File: tb/tb_uart_rx_word_assembler.sv
// Three assemblers share one byte stream: LSB-first with timeout, MSB-first
// with timeout, and LSB-first with the timeout disabled. A byte-list model
// predicts words and timeouts; a negedge monitor scores the DUT outputs.
module tb_uart_rx_word_assembler;
    import uart_rx_word_assembler_pkg::*;

    localparam int NBITS  = 32;
    localparam int BYTE_W = 8;
    localparam int NBYTES = 4;
    localparam int NDUT   = 3;

    typedef struct {
        logic [NBITS-1:0] word;
        int               cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] rx_byte = 8'h00;
    logic       rx_byte_done = 1'b0;
    logic       flush = 1'b0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    uart_rx_word_assembler_if #(.NBITS(NBITS), .BYTE_W(BYTE_W)) bus_a ();
    uart_rx_word_assembler_if #(.NBITS(NBITS), .BYTE_W(BYTE_W)) bus_b ();
    uart_rx_word_assembler_if #(.NBITS(NBITS), .BYTE_W(BYTE_W)) bus_c ();

    assign bus_a.rx_byte = rx_byte;  assign bus_a.rx_byte_done = rx_byte_done;  assign bus_a.flush = flush;
    assign bus_b.rx_byte = rx_byte;  assign bus_b.rx_byte_done = rx_byte_done;  assign bus_b.flush = flush;
    assign bus_c.rx_byte = rx_byte;  assign bus_c.rx_byte_done = rx_byte_done;  assign bus_c.flush = flush;

    uart_rx_word_assembler #(.NBITS(NBITS), .BYTE_W(BYTE_W), .LSB_FIRST(1), .TIMEOUT_CYC(20))
        dut_lsb (.clk(clk), .rst(rst), .bus(bus_a));
    uart_rx_word_assembler #(.NBITS(NBITS), .BYTE_W(BYTE_W), .LSB_FIRST(0), .TIMEOUT_CYC(20))
        dut_msb (.clk(clk), .rst(rst), .bus(bus_b));
    uart_rx_word_assembler #(.NBITS(NBITS), .BYTE_W(BYTE_W), .LSB_FIRST(1), .TIMEOUT_CYC(0))
        dut_nto (.clk(clk), .rst(rst), .bus(bus_c));

    logic [NBITS-1:0] wdata [NDUT];
    logic             wdone [NDUT];
    logic             terr  [NDUT];
    logic [1:0]       bcnt  [NDUT];

    assign wdata[0] = bus_a.word_data;  assign wdone[0] = bus_a.word_done;
    assign terr[0]  = bus_a.timeout_err; assign bcnt[0] = bus_a.byte_cnt;
    assign wdata[1] = bus_b.word_data;  assign wdone[1] = bus_b.word_done;
    assign terr[1]  = bus_b.timeout_err; assign bcnt[1] = bus_b.byte_cnt;
    assign wdata[2] = bus_c.word_data;  assign wdone[2] = bus_c.word_done;
    assign terr[2]  = bus_c.timeout_err; assign bcnt[2] = bus_c.byte_cnt;

    function automatic bit lsb_of(input int d);
        return d != 1;
    endfunction

    function automatic int to_of(input int d);
        return (d == 2) ? 0 : 20;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int         cyc = 0;
    logic [7:0] part      [NDUT][NBYTES];
    int         part_n    [NDUT];
    int         idle_n    [NDUT];
    logic [NBITS-1:0] last_word [NDUT];
    exp_t       word_q [NDUT][$];
    int         terr_q [NDUT][$];

    function automatic logic [NBITS-1:0] compose(input int d);
        logic [NBITS-1:0] w = '0;
        for (int k = 0; k < NBYTES; k++) begin
            int sh = lsb_of(d) ? 8 * k : 8 * (NBYTES - 1 - k);
            w = w | (NBITS'(part[d][k]) << sh);
        end
        return w;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int d = 0; d < NDUT; d++) begin
                part_n[d]    = 0;
                idle_n[d]    = 0;
                last_word[d] = '0;
                word_q[d].delete();
                terr_q[d].delete();
            end
        end else begin
            cyc++;
            for (int d = 0; d < NDUT; d++) begin
                if (flush) begin
                    part_n[d] = 0;
                    idle_n[d] = 0;
                end else if (rx_byte_done) begin
                    part[d][part_n[d]] = rx_byte;
                    part_n[d]++;
                    idle_n[d] = 0;
                    if (part_n[d] == NBYTES) begin
                        exp_t e;
                        e.word = compose(d);
                        e.cyc  = cyc;
                        word_q[d].push_back(e);
                        last_word[d] = e.word;
                        part_n[d]    = 0;
                    end
                end else if (part_n[d] > 0 && to_of(d) > 0) begin
                    idle_n[d]++;
                    if (idle_n[d] == to_of(d)) begin
                        terr_q[d].push_back(cyc);
                        part_n[d] = 0;
                        idle_n[d] = 0;
                    end
                end
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (rst) begin
            for (int d = 0; d < NDUT; d++) begin
                check($sformatf("byte_cnt[%0d]", d), 64'(bcnt[d]), 64'(part_n[d]));
                check($sformatf("word_data_hold[%0d]", d), 64'(wdata[d]), 64'(last_word[d]));
                if (wdone[d]) begin
                    if (word_q[d].size() == 0) begin
                        check($sformatf("unexpected_word_done[%0d]", d), 64'd1, 64'd0);
                    end else begin
                        exp_t e;
                        e = word_q[d].pop_front();
                        check($sformatf("word[%0d]", d), 64'(wdata[d]), 64'(e.word));
                        check($sformatf("word_latency_cyc[%0d]", d), 64'(cyc), 64'(e.cyc));
                    end
                end else if (word_q[d].size() > 0 && word_q[d][0].cyc <= cyc) begin
                    void'(word_q[d].pop_front());
                    check($sformatf("missing_word_done[%0d]", d), 64'd0, 64'd1);
                end
                if (terr[d]) begin
                    if (terr_q[d].size() == 0) begin
                        check($sformatf("unexpected_timeout_err[%0d]", d), 64'd1, 64'd0);
                    end else begin
                        int c;
                        c = terr_q[d].pop_front();
                        check($sformatf("timeout_cyc[%0d]", d), 64'(cyc), 64'(c));
                    end
                end else if (terr_q[d].size() > 0 && terr_q[d][0] <= cyc) begin
                    void'(terr_q[d].pop_front());
                    check($sformatf("missing_timeout_err[%0d]", d), 64'd0, 64'd1);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic d, input logic [7:0] b, input logic f);
        @(negedge clk);
        rx_byte_done = d;
        rx_byte      = b;
        flush        = f;
    endtask

    task automatic send(input logic [7:0] b);
        drive(1'b1, b, 1'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 8'($urandom), 1'b0);
    endtask

    task automatic do_flush();
        drive(1'b0, 8'h00, 1'b1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        for (int d = 0; d < NDUT; d++) begin
            check($sformatf("rst_word_data[%0d]", d), 64'(wdata[d]), 64'd0);
            check($sformatf("rst_byte_cnt[%0d]", d), 64'(bcnt[d]), 64'd0);
            check($sformatf("rst_word_done[%0d]", d), 64'(wdone[d]), 64'd0);
            check($sformatf("rst_timeout_err[%0d]", d), 64'(terr[d]), 64'd0);
        end
        rst = 1'b1;
        idle(2);

        // Spaced bytes: LSB-first and MSB-first orderings of the same stream.
        send(8'h11); idle(4); send(8'h22); idle(4); send(8'h33); idle(4); send(8'h44);
        idle(1);
        check("t1_done_lsb", 64'(wdone[0]), 64'd1);
        check("t1_word_lsb", 64'(wdata[0]), 64'h44332211);
        check("t1_word_msb", 64'(wdata[1]), 64'h11223344);
        check("t1_cnt_lsb", 64'(bcnt[0]), 64'd0);
        idle(3);

        // Eight back-to-back bytes produce two words.
        for (int i = 0; i < 8; i++) send(8'hA0 + 8'(i));
        idle(1);
        check("t2_word_msb", 64'(wdata[1]), 64'hA4A5A6A7);
        check("t2_word_lsb", 64'(wdata[0]), 64'hA7A6A5A4);
        idle(2);

        // Timeout after two bytes, then a clean word.
        do_flush();
        send(8'hDE); send(8'hAD); idle(20);
        idle(1);
        check("t3_timeout_lsb", 64'(terr[0]), 64'd1);
        check("t3_no_timeout_nto", 64'(terr[2]), 64'd0);
        check("t3_cnt_lsb", 64'(bcnt[0]), 64'd0);
        check("t3_word_kept", 64'(wdata[0]), 64'hA7A6A5A4);
        send(8'h01); send(8'h02); send(8'h03); send(8'h04);
        idle(1);
        check("t3_word_lsb", 64'(wdata[0]), 64'h04030201);

        // Byte on the idle cycle that would have expired wins.
        do_flush();
        send(8'h10); send(8'h20); idle(19); send(8'h30);
        idle(1);
        check("t4_cnt_lsb", 64'(bcnt[0]), 64'd3);
        check("t4_no_timeout", 64'(terr[0]), 64'd0);
        send(8'h40);
        idle(1);
        check("t4_word_lsb", 64'(wdata[0]), 64'h40302010);

        // Flush together with the fourth byte drops the word.
        do_flush();
        send(8'h51); send(8'h52); send(8'h53); drive(1'b1, 8'h54, 1'b1);
        idle(1);
        check("t5_no_done", 64'(wdone[0]), 64'd0);
        check("t5_cnt", 64'(bcnt[0]), 64'd0);
        check("t5_word_kept", 64'(wdata[0]), 64'h40302010);
        send(8'h61); send(8'h62); send(8'h63); send(8'h64);
        idle(1);
        check("t5_word_lsb", 64'(wdata[0]), 64'h64636261);

        // Asynchronous reset mid-word.
        do_flush();
        send(8'h71); send(8'h72);
        @(posedge clk);
        #3;
        rst = 1'b0;
        rx_byte_done = 1'b0;
        #1;
        for (int d = 0; d < NDUT; d++) begin
            check($sformatf("t6_rst_word[%0d]", d), 64'(wdata[d]), 64'd0);
            check($sformatf("t6_rst_cnt[%0d]", d), 64'(bcnt[d]), 64'd0);
            check($sformatf("t6_rst_done[%0d]", d), 64'(wdone[d]), 64'd0);
            check($sformatf("t6_rst_terr[%0d]", d), 64'(terr[d]), 64'd0);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        send(8'h81); send(8'h82); send(8'h83); send(8'h84);
        idle(1);
        check("t6_word_lsb", 64'(wdata[0]), 64'h84838281);

        // Timeout disabled: a long mid-word gap keeps the partial word.
        do_flush();
        send(8'h91); send(8'h92); idle(1000);
        check("t6_nto_cnt", 64'(bcnt[2]), 64'd2);
        do_flush();

        // Randomized traffic with occasional flushes and long gaps.
        for (int i = 0; i < 400; i++) begin
            int r = $urandom_range(0, 99);
            if (r < 4)        do_flush();
            else if (r < 60)  send(8'($urandom));
            else if (r < 95)  idle($urandom_range(1, 3));
            else              idle($urandom_range(15, 25));
        end
        idle(5);
        for (int d = 0; d < NDUT; d++) begin
            check($sformatf("end_word_q_empty[%0d]", d), 64'(word_q[d].size()), 64'd0);
            check($sformatf("end_terr_q_empty[%0d]", d), 64'(terr_q[d].size()), 64'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
